// File: rtl/npu_pkg.sv
// Shared definitions for the NPU sequencer: FSM encoding, lane geometry and
// default array latency.
package npu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } npu_state_t;

    localparam int NUM_LANES   = 3;
    localparam int LANE_W      = 8;
    localparam int RES_W       = 16;
    localparam int ARR_LAT_DEF = 3;

endpackage

// File: rtl/npu_skew_line.sv
// Fixed-depth delay line with synchronous reset, used for the row skew,
// the column de-skew and the write-valid pipeline; DEPTH=0 is a plain wire.
module npu_skew_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 0
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = wb_clk_i ^ wb_rst_i;
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];
            logic [WIDTH-1:0] stage_d [DEPTH];

            always_comb begin
                stage_d[0] = din;
                for (int s = 1; s < DEPTH; s++) begin
                    stage_d[s] = stage_q[s-1];
                end
            end

            always_ff @(posedge wb_clk_i) begin
                for (int s = 0; s < DEPTH; s++) begin
                    if (wb_rst_i) stage_q[s] <= '0;
                    else          stage_q[s] <= stage_d[s];
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/npu_seq_ctrl.sv
// Job sequencer for a 3x3 systolic array: fetch, skewed feed, de-skewed writeback.
// Optional busy-cycle counter output perf_cycles when NPU_SEQ_PERF_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | read of address 0 in flight
// FEED  | arr_en high for num_vec+2 cycles while rows stream in
// DRAIN | array drains until the last result is captured and written
// DONE  | one-cycle done pulse, busy low
module npu_seq_ctrl
    import npu_pkg::*;
#(
    parameter int NVEC_W  = 8,
    parameter int ARR_LAT = ARR_LAT_DEF
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         start,
    input  logic [NVEC_W-1:0]            num_vec,
    output logic                         busy,
    output logic                         done,
    output logic                         act_rd_en,
    output logic [NVEC_W-1:0]            act_rd_addr,
    input  logic [NUM_LANES*LANE_W-1:0]  act_rd_data,
    output logic                         arr_en,
    output logic [NUM_LANES*LANE_W-1:0]  arr_left,
    input  logic [NUM_LANES*RES_W-1:0]   arr_down,
    output logic                         res_wr_en,
    output logic [NVEC_W-1:0]            res_wr_addr,
`ifdef NPU_SEQ_PERF_EN
    output logic [15:0]                  perf_cycles,
`endif
    output logic [NUM_LANES*RES_W-1:0]   res_wr_data
);

    localparam int CNT_W = NVEC_W + 1;

    npu_state_t                 state_q, state_d;
    logic [NVEC_W-1:0]          num_q, num_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       act_rd_en_q, act_rd_en_d;
    logic [NVEC_W-1:0]          act_rd_addr_q, act_rd_addr_d;
    logic                       rd_vld_q, rd_vld_d;
    logic                       arr_en_q, arr_en_d;
    logic                       res_wr_en_q, res_wr_en_d;
    logic [NVEC_W-1:0]          res_wr_addr_q, res_wr_addr_d;
    logic [NVEC_W-1:0]          wr_cnt_q, wr_cnt_d;
    logic [NUM_LANES*RES_W-1:0] res_wr_data_q, res_wr_data_d;
    logic [NUM_LANES*RES_W-1:0] aligned;
    logic                       wr_pre;
    logic                       accept;
`ifdef NPU_SEQ_PERF_EN
    logic [15:0]                perf_q, perf_d;
`endif

    assign accept = (state_q == ST_IDLE) && start;

    always_comb begin
        state_d       = state_q;
        num_d         = num_q;
        cnt_d         = cnt_q;
        act_rd_en_d   = 1'b0;
        act_rd_addr_d = act_rd_addr_q;
        res_wr_addr_d = res_wr_addr_q;
        res_wr_data_d = res_wr_data_q;
        wr_cnt_d      = accept ? '0 : wr_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_d   = num_vec;
                    state_d = (num_vec == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_FEED;
                cnt_d   = {1'b0, num_q} + CNT_W'(1);
            end
            ST_FEED: begin
                if (cnt_q == '0) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_W'(ARR_LAT);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) state_d = ST_DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Reads stream back-to-back from the accepting edge until num_vec-1.
        if (accept && (num_vec != '0)) begin
            act_rd_en_d   = 1'b1;
            act_rd_addr_d = '0;
        end else if (act_rd_en_q && (act_rd_addr_q != num_q - NVEC_W'(1))) begin
            act_rd_en_d   = 1'b1;
            act_rd_addr_d = act_rd_addr_q + NVEC_W'(1);
        end
        rd_vld_d = act_rd_en_q;

        // DRAIN's last cycle carries the final write; the array is already done.
        arr_en_d = (state_d == ST_FEED) || ((state_d == ST_DRAIN) && (cnt_d != '0));
        busy_d   = (state_d == ST_FETCH) || (state_d == ST_FEED) || (state_d == ST_DRAIN);
        done_d   = (state_d == ST_DONE);

        res_wr_en_d = wr_pre;
        if (wr_pre) begin
            res_wr_addr_d = wr_cnt_q;
            wr_cnt_d      = wr_cnt_q + NVEC_W'(1);
            res_wr_data_d = aligned;
        end

`ifdef NPU_SEQ_PERF_EN
        perf_d = perf_q;
        if (accept)                             perf_d = '0;
        else if (busy_q && (perf_q != 16'hFFFF)) perf_d = perf_q + 16'd1;
`endif
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q       <= ST_IDLE;
            num_q         <= '0;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            act_rd_en_q   <= 1'b0;
            act_rd_addr_q <= '0;
            rd_vld_q      <= 1'b0;
            arr_en_q      <= 1'b0;
            res_wr_en_q   <= 1'b0;
            res_wr_addr_q <= '0;
            wr_cnt_q      <= '0;
            res_wr_data_q <= '0;
`ifdef NPU_SEQ_PERF_EN
            perf_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            num_q         <= num_d;
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            act_rd_en_q   <= act_rd_en_d;
            act_rd_addr_q <= act_rd_addr_d;
            rd_vld_q      <= rd_vld_d;
            arr_en_q      <= arr_en_d;
            res_wr_en_q   <= res_wr_en_d;
            res_wr_addr_q <= res_wr_addr_d;
            wr_cnt_q      <= wr_cnt_d;
            res_wr_data_q <= res_wr_data_d;
`ifdef NPU_SEQ_PERF_EN
            perf_q        <= perf_d;
`endif
        end
    end

    // Lane i is delayed i cycles on entry; column j is delayed 2-j on exit.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [LANE_W-1:0] lane_in;
        assign lane_in = rd_vld_q ? act_rd_data[LANE_W*i +: LANE_W] : '0;

        npu_skew_line #(.WIDTH(LANE_W), .DEPTH(i)) u_skew (
            .wb_clk_i (wb_clk_i),
            .wb_rst_i (wb_rst_i),
            .din      (lane_in),
            .dout     (arr_left[LANE_W*i +: LANE_W])
        );

        npu_skew_line #(.WIDTH(RES_W), .DEPTH(NUM_LANES-1-i)) u_deskew (
            .wb_clk_i (wb_clk_i),
            .wb_rst_i (wb_rst_i),
            .din      (arr_down[RES_W*i +: RES_W]),
            .dout     (aligned[RES_W*i +: RES_W])
        );
    end

    npu_skew_line #(.WIDTH(1), .DEPTH(ARR_LAT + NUM_LANES - 1)) u_wr_vld (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .din      (rd_vld_q),
        .dout     (wr_pre)
    );

    assign busy        = busy_q;
    assign done        = done_q;
    assign act_rd_en   = act_rd_en_q;
    assign act_rd_addr = act_rd_addr_q;
    assign arr_en      = arr_en_q;
    assign res_wr_en   = res_wr_en_q;
    assign res_wr_addr = res_wr_addr_q;
    assign res_wr_data = res_wr_data_q;
`ifdef NPU_SEQ_PERF_EN
    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_npu_seq_ctrl.sv
// Directed bench for npu_seq_ctrl with a behavioural activation buffer and an
// identity-weight 3x3 array model; perf_cycles is exercised under NPU_SEQ_PERF_EN.
module tb_npu_seq_ctrl;

    localparam int L = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  num_vec;
    logic        busy, done, act_rd_en, arr_en, res_wr_en;
    logic [7:0]  act_rd_addr, res_wr_addr;
    logic [23:0] act_rd_data, arr_left;
    logic [47:0] arr_down, res_wr_data;
`ifdef NPU_SEQ_PERF_EN
    logic [15:0] perf_cycles;
`endif

    always #5 clk = ~clk;

    npu_seq_ctrl #(.NVEC_W(8), .ARR_LAT(L)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .start       (start),
        .num_vec     (num_vec),
        .busy        (busy),
        .done        (done),
        .act_rd_en   (act_rd_en),
        .act_rd_addr (act_rd_addr),
        .act_rd_data (act_rd_data),
        .arr_en      (arr_en),
        .arr_left    (arr_left),
        .arr_down    (arr_down),
        .res_wr_en   (res_wr_en),
        .res_wr_addr (res_wr_addr),
`ifdef NPU_SEQ_PERF_EN
        .perf_cycles (perf_cycles),
`endif
        .res_wr_data (res_wr_data)
    );

    // Activation buffer: one-cycle read latency.
    logic [23:0] act_mem [256];
    always @(posedge clk) if (act_rd_en) act_rd_data <= act_mem[act_rd_addr];

    // Identity-weight array: column j emits lane j, L cycles later, zero-extended.
    logic [23:0] pipe [L];
    always @(posedge clk) begin
        pipe[0] <= arr_left;
        for (int s = 1; s < L; s++) pipe[s] <= pipe[s-1];
    end
    assign arr_down = {8'h00, pipe[L-1][23:16], 8'h00, pipe[L-1][15:8], 8'h00, pipe[L-1][7:0]};

    int cyc = 0, busy_cyc = 0, done_cnt = 0, rd_cnt = 0, arr_cnt = 0, wr_cnt = 0;
    logic [7:0]  wr_addr_log [64];
    logic [47:0] wr_data_log [64];
    int          wr_cyc_log  [64];

    always @(posedge clk) begin
        if (busy)      busy_cyc++;
        if (done)      done_cnt++;
        if (act_rd_en) rd_cnt++;
        if (arr_en)    arr_cnt++;
        if (res_wr_en) begin
            if (wr_cnt < 64) begin
                wr_addr_log[wr_cnt] = res_wr_addr;
                wr_data_log[wr_cnt] = res_wr_data;
                wr_cyc_log[wr_cnt]  = cyc;
            end
            wr_cnt++;
        end
        cyc++;
    end

    int errors = 0, checks = 0;
    int acc_cyc, done_base, wr_base, rd_base, arr_base, busy_base;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic snap();
        done_base = done_cnt; wr_base = wr_cnt; rd_base = rd_cnt;
        arr_base  = arr_cnt;  busy_base = busy_cyc;
    endtask

    task automatic launch(input int n);
        @(negedge clk);
        snap();
        start = 1'b1; num_vec = 8'(n); acc_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (done_cnt > done_base) break;
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, 64'(done_cnt > done_base), 64'd1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},   64'(busy), 0);
        chk({tag, "_done"},   64'(done), 0);
        chk({tag, "_rd_en"},  64'(act_rd_en), 0);
        chk({tag, "_rd_addr"},64'(act_rd_addr), 0);
        chk({tag, "_arr_en"}, 64'(arr_en), 0);
        chk({tag, "_left"},   64'(arr_left), 0);
        chk({tag, "_wr_en"},  64'(res_wr_en), 0);
        chk({tag, "_wr_addr"},64'(res_wr_addr), 0);
        chk({tag, "_wr_data"},64'(res_wr_data), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_vec = '0;
        tick(5);
        chk_idle_outputs("reset");
        rst = 1'b0;

        // Single vector: skew timing, one write, done pulse.
        act_mem[0] = 24'h030201;
        launch(1);
        chk("t1_fetch_busy",  64'(busy), 1);
        chk("t1_fetch_rd_en", 64'(act_rd_en), 1);
        chk("t1_fetch_addr",  64'(act_rd_addr), 0);
        @(negedge clk);
        chk("t1_f0_left",   64'(arr_left), 64'h000001);
        chk("t1_f0_arr_en", 64'(arr_en), 1);
        chk("t1_f0_rd_en",  64'(act_rd_en), 0);
        @(negedge clk);
        chk("t1_f1_left", 64'(arr_left), 64'h000200);
        @(negedge clk);
        chk("t1_f2_left", 64'(arr_left), 64'h030000);
        @(negedge clk);
        chk("t1_f3_left", 64'(arr_left), 64'h000000);
        chk("t1_f3_arr_en", 64'(arr_en), 1);
        tick(3);
        chk("t1_wr_en",   64'(res_wr_en), 1);
        chk("t1_wr_addr", 64'(res_wr_addr), 0);
        chk("t1_wr_data", 64'(res_wr_data), 64'h0000_0003_0002_0001);
        chk("t1_wr_arr_en", 64'(arr_en), 0);
        chk("t1_wr_cycle", 64'(cyc - acc_cyc), 64'(5 + L));
        @(negedge clk);
        chk("t1_done",      64'(done), 1);
        chk("t1_done_busy", 64'(busy), 0);
        chk("t1_done_wr",   64'(res_wr_en), 0);
        @(negedge clk);
        chk("t1_done_pulse", 64'(done), 0);
        chk("t1_writes", 64'(wr_cnt - wr_base), 1);

        // Four vectors through the array model.
        act_mem[0] = 24'h0A0B0C; act_mem[1] = 24'hFF8001;
        act_mem[2] = 24'h123456; act_mem[3] = 24'h7F00FE;
        launch(4);
        wait_done("t2");
        chk("t2_writes", 64'(wr_cnt - wr_base), 4);
        chk("t2_reads",  64'(rd_cnt - rd_base), 4);
        chk("t2_arr_en_cycles", 64'(arr_cnt - arr_base), 9);
        chk("t2_busy_cycles",   64'(busy_cyc - busy_base), 11);
        chk("t2_first_wr_lat",  64'(wr_cyc_log[wr_base] - acc_cyc), 64'(5 + L));
        chk("t2_d0", wr_data_log[wr_base+0], 64'h000A000B000C);
        chk("t2_d1", wr_data_log[wr_base+1], 64'h00FF00800001);
        chk("t2_d2", wr_data_log[wr_base+2], 64'h001200340056);
        chk("t2_d3", wr_data_log[wr_base+3], 64'h007F000000FE);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_addr%0d", k), 64'(wr_addr_log[wr_base+k]), 64'(k));
            chk($sformatf("t2_gap%0d", k), 64'(wr_cyc_log[wr_base+k] - wr_cyc_log[wr_base]), 64'(k));
        end

        // num_vec = 0: immediate done, no traffic.
        tick(2);
        launch(0);
        chk("t3_done", 64'(done), 1);
        chk("t3_busy", 64'(busy), 0);
        @(negedge clk);
        chk("t3_done_pulse", 64'(done), 0);
        tick(10);
        chk("t3_no_reads",  64'(rd_cnt - rd_base), 0);
        chk("t3_no_arr_en", 64'(arr_cnt - arr_base), 0);
        chk("t3_no_writes", 64'(wr_cnt - wr_base), 0);

        // Start while busy is ignored.
        launch(3);
        tick(2);
        start = 1'b1; num_vec = 8'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done("t4");
        tick(5);
        chk("t4_writes",    64'(wr_cnt - wr_base), 3);
        chk("t4_done_once", 64'(done_cnt - done_base), 1);
        chk("t4_last_addr", 64'(wr_addr_log[wr_cnt-1]), 2);

        // Reset two cycles into FEED aborts the job.
        launch(4);
        tick(2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_outputs("t5_abort");
        tick(15);
        chk("t5_no_writes", 64'(wr_cnt - wr_base), 0);
        chk("t5_no_done",   64'(done_cnt - done_base), 0);
        launch(2);
        wait_done("t5_new");
        chk("t5_new_writes", 64'(wr_cnt - wr_base), 2);
        chk("t5_new_d0", wr_data_log[wr_base+0], 64'h000A000B000C);
        chk("t5_new_d1", wr_data_log[wr_base+1], 64'h00FF00800001);
        chk("t5_new_a1", 64'(wr_addr_log[wr_base+1]), 1);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; num_vec = 8'd2;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        tick(2);
        chk("t6_rst_prio_busy",  64'(busy), 0);
        chk("t6_rst_prio_rd_en", 64'(act_rd_en), 0);

`ifdef NPU_SEQ_PERF_EN
        for (int k = 0; k < 8; k++) act_mem[k] = 24'(k * 24'h010101);
        launch(8);
        wait_done("t7");
        chk("t7_busy_cycles", 64'(busy_cyc - busy_base), 64'(8 + L + 4));
        chk("t7_perf",        64'(perf_cycles), 64'(busy_cyc - busy_base));
        tick(5);
        chk("t7_perf_hold",   64'(perf_cycles), 64'(8 + L + 4));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
